div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
Sequential front/back-end stage wrapped around the combinational 16/8 divider of the arithmetic unit.
- Collects a 16-bit dividend and an 8-bit divisor from the 8-bit ALU operand bus as three handshaked bytes.
- Screens divide-by-zero and quotient overflow, presents stable operands to the divider, and waits a fixed settle time.
- Captures quotient and remainder into a result register, with a valid/ready handshake towards the ALU result mux.

Parameters:
- DIV_LATENCY, 2, cycles the divider operands are held stable before its outputs are sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand byte valid
- in_ready  output  1  block accepts an operand byte
- in_data  input  8  operand byte; order is dividend[15:8], dividend[7:0], divisor
- div_dividend  output  16  registered dividend driven to the divider
- div_divisor  output  8  registered divisor driven to the divider
- div_quotient  input  8  divider quotient
- div_remainder  input  8  divider remainder
- res_valid  output  1  result register holds a result
- res_ready  input  1  consumer accepts the result
- res_quotient  output  8  captured quotient
- res_remainder  output  8  captured remainder
- res_div0  output  1  divisor was zero
- res_ovf  output  1  quotient does not fit in 8 bits
- busy  output  1  high in any state other than COLLECT with byte_cnt=0

Behaviour:
- Clocking: single clock domain. rst is sampled only on the rising edge of clk.
- Reset state: COLLECT with byte_cnt=0. All of these are 0: in_ready=1, res_valid, res_quotient, res_remainder, res_div0, res_ovf, div_dividend, div_divisor, busy, wait_cnt.
- A transfer happens when in_valid && in_ready, or res_valid && res_ready, at a rising edge.
- COLLECT state:
  - in_ready=1.
  - Each accepted byte is stored by byte_cnt: 0 -> dividend[15:8], 1 -> dividend[7:0], 2 -> divisor.
  - byte_cnt increments after each accepted byte.
  - On the third byte, div_dividend and div_divisor load on the same edge and byte_cnt clears.
  - Next state on the third byte:
    - If divisor==0: go to RESULT with res_div0=1, res_quotient=8'hFF, res_remainder=dividend[7:0].
    - Else if dividend[15:8] >= divisor: go to RESULT with res_ovf=1, res_quotient=8'hFF, res_remainder=8'hFF.
    - Else: go to WAIT with wait_cnt=DIV_LATENCY-1.
- WAIT state:
  - in_ready=0; div_* outputs are held constant.
  - wait_cnt decrements each cycle.
  - In the cycle wait_cnt==0: capture div_quotient and div_remainder into res_*, clear both flags, go to RESULT.
  - Latency from third byte accepted to res_valid=1 is DIV_LATENCY+1 cycles.
- RESULT state:
  - res_valid=1 and in_ready=0.
  - All res_* outputs stay stable until the handshake completes.
  - On res_ready: res_valid drops on the next edge and the state returns to COLLECT.
  - The block does not accept input in the same cycle as the result handshake.
  - Error-path latency (div0/ovf) is 1 cycle from third byte to res_valid.
- Flags: res_div0 and res_ovf are mutually exclusive; div0 has priority.
- Widths: the overflow test compares dividend[15:8] against the 8-bit divisor as unsigned values. All arithmetic is unsigned.
- Reset mid-operation: rst in any state returns the block to the reset state on that edge.
  - A partially collected operand set is discarded.
  - A pending result is dropped without a handshake.
- Simultaneous rst with a transfer: rst wins.
- in_data is ignored whenever in_ready=0.

Decomposition:
- Shared package div_pkg:
  - state encoding enum (COLLECT, WAIT, RESULT)
  - byte index constants BYTE_HI=0, BYTE_LO=1, BYTE_DIV=2
  - error-value constants DIV_ERR_Q=8'hFF, OVF_ERR_R=8'hFF
  - function div_fits(dividend, divisor) returning dividend[15:8] < divisor
- One natural sub-module, div_settle_counter: loadable down-counter with zero flag, used for WAIT.
- Operand collection and result register stay in the top module.

Test Plan:
- Bytes 00,64,07 with DIV_LATENCY=2 and a correct divider model -> res_valid 3 cycles after the third byte; q=0x0E, r=0x02, flags 0.
- Bytes 12,34,00 -> res_valid 1 cycle after the third byte; res_div0=1, q=0xFF, r=0x34, res_ovf=0; divider outputs not sampled.
- Bytes 09,00,08 -> res_ovf=1, q=0xFF, r=0xFF. Boundary bytes 07,FF,08 -> q=0xFF, r=0x07, ovf=0.
- Hold res_ready=0 for 5 cycles after result 0x0E/0x02 while driving in_valid=1 -> in_ready stays 0, res_* unchanged. Then assert res_ready -> next edge res_valid=0 and in_ready=1.
- Assert rst after 2 bytes, then separately mid-WAIT -> next edge all outputs 0 and state COLLECT. A fresh 00,64,07 sequence then gives q=0x0E, r=0x02.
- Run DIV_LATENCY=1 and 15 with 00,64,07 -> res_valid exactly 2 and 16 cycles after the third byte; div_* stable throughout WAIT.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue/collect stage.
package div_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned DIVIDEND_W = 16;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned BYTE_CNT_W = 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    RESULT  = 2'd2
  } div_state_t;

  localparam logic [BYTE_CNT_W-1:0] BYTE_HI  = 2'd0;
  localparam logic [BYTE_CNT_W-1:0] BYTE_LO  = 2'd1;
  localparam logic [BYTE_CNT_W-1:0] BYTE_DIV = 2'd2;

  localparam logic [DATA_W-1:0] DIV_ERR_Q = 8'hFF;
  localparam logic [DATA_W-1:0] OVF_ERR_R = 8'hFF;

  typedef struct packed {
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              div0;
    logic              ovf;
  } div_res_t;

  // Quotient fits in 8 bits iff dividend < divisor * 256, i.e. dividend[15:8] < divisor.
  function automatic logic div_fits(input logic [DIVIDEND_W-1:0] dividend,
                                    input logic [DATA_W-1:0]     divisor);
    return dividend < {divisor, 8'h00};
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Operand bus, divider connection and result handshake of the divider issue stage.
interface div_issue_ctrl_if;
  import div_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic [DIVIDEND_W-1:0] div_dividend;
  logic [DATA_W-1:0]     div_divisor;
  logic [DATA_W-1:0]     div_quotient;
  logic [DATA_W-1:0]     div_remainder;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_W-1:0]     res_quotient;
  logic [DATA_W-1:0]     res_remainder;
  logic                  res_div0;
  logic                  res_ovf;
  logic                  busy;

  modport slave (
    input  in_valid, in_data, div_quotient, div_remainder, res_ready,
    output in_ready, div_dividend, div_divisor, res_valid,
           res_quotient, res_remainder, res_div0, res_ovf, busy
  );

  modport master (
    output in_valid, in_data, div_quotient, div_remainder, res_ready,
    input  in_ready, div_dividend, div_divisor, res_valid,
           res_quotient, res_remainder, res_div0, res_ovf, busy
  );

endinterface

// File: rtl/div_settle_counter.sv
// Loadable down-counter timing the divider settle window.
module div_settle_counter
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero_c
);

  assign zero_c = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero_c) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Collects dividend/divisor bytes, screens div0/overflow, waits for the divider
// to settle and holds the captured result until the consumer takes it.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  div_issue_ctrl_if.slave bus
);

  div_state_t             state;
  logic [BYTE_CNT_W-1:0]  byte_cnt;
  logic [DATA_W-1:0]      hi_q;
  logic [DATA_W-1:0]      lo_q;
  logic [DIVIDEND_W-1:0]  dividend_q;
  logic [DATA_W-1:0]      divisor_q;
  div_res_t               res_q;
  logic                   res_valid_q;
  logic                   in_ready_q;
  logic                   busy_q;

  logic                   in_fire_c;
  logic                   last_byte_c;
  logic [DIVIDEND_W-1:0]  dividend_c;
  logic                   cnt_load_c;
  logic [CNT_W-1:0]       wait_cnt;
  logic                   wait_zero_c;

  assign in_fire_c   = bus.in_valid && in_ready_q;
  assign last_byte_c = in_fire_c && (byte_cnt == BYTE_DIV);
  assign dividend_c  = {hi_q, lo_q};
  assign cnt_load_c  = last_byte_c && (bus.in_data != '0) && div_fits(dividend_c, bus.in_data);

  div_settle_counter u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_c),
    .load_val (CNT_W'(DIV_LATENCY - 1)),
    .dec      (state == WAIT),
    .cnt      (wait_cnt),
    .zero_c   (wait_zero_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      byte_cnt    <= BYTE_HI;
      hi_q        <= '0;
      lo_q        <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_fire_c) begin
            busy_q <= 1'b1;
            case (byte_cnt)
              BYTE_HI: begin
                hi_q     <= bus.in_data;
                byte_cnt <= BYTE_LO;
              end
              BYTE_LO: begin
                lo_q     <= bus.in_data;
                byte_cnt <= BYTE_DIV;
              end
              default: begin
                byte_cnt   <= BYTE_HI;
                dividend_q <= dividend_c;
                divisor_q  <= bus.in_data;
                in_ready_q <= 1'b0;
                // Error results skip the divider entirely; div0 outranks overflow.
                if (bus.in_data == '0) begin
                  res_q       <= '{quotient: DIV_ERR_Q, remainder: lo_q, div0: 1'b1, ovf: 1'b0};
                  res_valid_q <= 1'b1;
                  state       <= RESULT;
                end else if (!div_fits(dividend_c, bus.in_data)) begin
                  res_q       <= '{quotient: DIV_ERR_Q, remainder: OVF_ERR_R, div0: 1'b0, ovf: 1'b1};
                  res_valid_q <= 1'b1;
                  state       <= RESULT;
                end else begin
                  state <= WAIT;
                end
              end
            endcase
          end
        end
        WAIT: begin
          if (wait_zero_c) begin
            res_q       <= '{quotient: bus.div_quotient, remainder: bus.div_remainder,
                             div0: 1'b0, ovf: 1'b0};
            res_valid_q <= 1'b1;
            state       <= RESULT;
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.div_dividend  = dividend_q;
  assign bus.div_divisor   = divisor_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_quotient  = res_q.quotient;
  assign bus.res_remainder = res_q.remainder;
  assign bus.res_div0      = res_q.div0;
  assign bus.res_ovf       = res_q.ovf;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl: directed operand sets, a divider model
// per instance, and a separate monitor that checks results as they appear.
module tb_div_issue_ctrl;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  div_issue_ctrl_if bus2 ();
  div_issue_ctrl_if busa ();
  div_issue_ctrl_if busb ();

  div_issue_ctrl #(.DIV_LATENCY(2))  u_dut  (.clk(clk), .rst(rst), .bus(bus2));
  div_issue_ctrl #(.DIV_LATENCY(1))  u_dut1 (.clk(clk), .rst(rst), .bus(busa));
  div_issue_ctrl #(.DIV_LATENCY(15)) u_dut15(.clk(clk), .rst(rst), .bus(busb));

  function automatic logic [15:0] div_model(input logic [15:0] dd, input logic [7:0] dv);
    logic [15:0] q;
    logic [15:0] r;
    if (dv == 8'h00) return 16'h0000;
    q = dd / {8'h00, dv};
    r = dd % {8'h00, dv};
    return {q[7:0], r[7:0]};
  endfunction

  assign {bus2.div_quotient, bus2.div_remainder} = div_model(bus2.div_dividend, bus2.div_divisor);
  assign {busa.div_quotient, busa.div_remainder} = div_model(busa.div_dividend, busa.div_divisor);
  assign {busb.div_quotient, busb.div_remainder} = div_model(busb.div_dividend, busb.div_divisor);

  // Secondary instances share one stimulus and always accept results.
  logic       x_valid;
  logic [7:0] x_data;
  assign busa.in_valid  = x_valid;
  assign busa.in_data   = x_data;
  assign busa.res_ready = 1'b1;
  assign busb.in_valid  = x_valid;
  assign busb.in_data   = x_data;
  assign busb.res_ready = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic        div0;
    logic        ovf;
    logic [15:0] dd;
    logic [7:0]  dv;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  // Monitor: samples 1 time unit after each falling edge.
  logic       prev_v = 1'b0;
  logic       prev_hs = 1'b0;
  logic       prev_rst = 1'b1;
  logic [7:0] snap_q, snap_r;
  logic       snap_d0, snap_ov;

  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (bus2.res_valid) begin
      chk("res_in_ready_low", 32'(bus2.in_ready), 32'd0);
      if (!prev_v) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("res_quotient",  32'(bus2.res_quotient),  32'(e.q));
          chk("res_remainder", 32'(bus2.res_remainder), 32'(e.r));
          chk("res_div0",      32'(bus2.res_div0),      32'(e.div0));
          chk("res_ovf",       32'(bus2.res_ovf),       32'(e.ovf));
          chk("div_dividend",  32'(bus2.div_dividend),  32'(e.dd));
          chk("div_divisor",   32'(bus2.div_divisor),   32'(e.dv));
          chk("res_latency",   32'(cyc - e.acc),        32'(e.lat));
        end
      end else if (!prev_hs) begin
        chk("hold_quotient",  32'(bus2.res_quotient),  32'(snap_q));
        chk("hold_remainder", 32'(bus2.res_remainder), 32'(snap_r));
        chk("hold_div0",      32'(bus2.res_div0),      32'(snap_d0));
        chk("hold_ovf",       32'(bus2.res_ovf),       32'(snap_ov));
      end
      snap_q  = bus2.res_quotient;
      snap_r  = bus2.res_remainder;
      snap_d0 = bus2.res_div0;
      snap_ov = bus2.res_ovf;
    end else if (prev_v && !prev_hs && !prev_rst) begin
      chk("res_valid_held", 32'd0, 32'd1);
    end
    prev_v   = bus2.res_valid;
    prev_hs  = bus2.res_valid && bus2.res_ready;
    prev_rst = rst;
  end

  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus2.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus2.in_ready) chk("in_ready_wait", 32'(bus2.in_ready), 32'd1);
    bus2.in_valid = 1'b1;
    bus2.in_data  = b;
    acc_cyc       = cyc;
    @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    bus2.in_data  = 8'hA5;
  endtask

  task automatic send_txn(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] dv,
                          input logic [7:0] q, input logic [7:0] r, input logic d0,
                          input logic ov, input int lat, input logic push);
    int a;
    exp_t e;
    send_byte(hi, a);
    send_byte(lo, a);
    send_byte(dv, a);
    if (push) begin
      e = '{q: q, r: r, div0: d0, ovf: ov, dd: {hi, lo}, dv: dv, acc: a, lat: lat};
      sbq.push_back(e);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  32'(bus2.in_ready),      32'd1);
    chk({tag, "_res_valid"}, 32'(bus2.res_valid),     32'd0);
    chk({tag, "_res_q"},     32'(bus2.res_quotient),  32'd0);
    chk({tag, "_res_r"},     32'(bus2.res_remainder), 32'd0);
    chk({tag, "_div0"},      32'(bus2.res_div0),      32'd0);
    chk({tag, "_ovf"},       32'(bus2.res_ovf),       32'd0);
    chk({tag, "_dividend"},  32'(bus2.div_dividend),  32'd0);
    chk({tag, "_divisor"},   32'(bus2.div_divisor),   32'd0);
    chk({tag, "_busy"},      32'(bus2.busy),          32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sbq.size() != 0 || bus2.res_valid); i++) @(negedge clk);
    if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat_a;
    int lat_b;
    rst            = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = 8'h00;
    bus2.res_ready = 1'b1;
    x_valid        = 1'b0;
    x_data         = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // Normal, div0, overflow and the largest quotient that still fits.
    send_txn(8'h00, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 3, 1'b1);
    send_txn(8'h12, 8'h34, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1, 1'b1);
    send_txn(8'h09, 8'h00, 8'h08, 8'hFF, 8'hFF, 1'b0, 1'b1, 1, 1'b1);
    send_txn(8'h07, 8'hFF, 8'h08, 8'hFF, 8'h07, 1'b0, 1'b0, 3, 1'b1);
    drain();

    // Back-pressure on the result while operand bytes keep arriving.
    bus2.res_ready = 1'b0;
    send_txn(8'h00, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 3, 1'b1);
    bus2.in_valid = 1'b1;
    bus2.in_data  = 8'h55;
    n = 0;
    while (!bus2.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_res_valid_seen", 32'(bus2.res_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(bus2.in_ready), 32'd0);
      chk("hold_busy",     32'(bus2.busy),     32'd1);
    end
    bus2.res_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    @(posedge clk);
    #1;
    chk("release_res_valid", 32'(bus2.res_valid), 32'd0);
    chk("release_in_ready",  32'(bus2.in_ready),  32'd1);
    chk("release_busy",      32'(bus2.busy),      32'd0);

    // Reset with a partial operand set.
    begin
      int a;
      send_byte(8'h12, a);
      send_byte(8'h34, a);
    end
    chk("partial_busy", 32'(bus2.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("rst_partial");
    @(negedge clk);
    rst = 1'b0;

    // Reset while the divider is settling.
    send_txn(8'h00, 8'h64, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    chk("wait_busy",     32'(bus2.busy),     32'd1);
    chk("wait_in_ready", 32'(bus2.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("rst_wait");
    @(negedge clk);
    rst = 1'b0;

    send_txn(8'h00, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 3, 1'b1);
    drain();

    // Latency extremes on the side instances.
    @(negedge clk);
    x_valid = 1'b1;
    x_data  = 8'h00;
    @(negedge clk);
    x_data  = 8'h64;
    @(negedge clk);
    x_data  = 8'h07;
    lat_a = 0;
    lat_b = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      x_valid = 1'b0;
      x_data  = 8'hC3;
      #1;
      if (busa.res_valid && lat_a == 0) lat_a = k;
      if (busb.res_valid && lat_b == 0) lat_b = k;
      if (busb.busy && !busb.res_valid) begin
        chk("l15_dividend_stable", 32'(busb.div_dividend), 32'h0064);
        chk("l15_divisor_stable",  32'(busb.div_divisor),  32'h07);
      end
    end
    chk("l1_latency",  32'(lat_a), 32'd2);
    chk("l15_latency", 32'(lat_b), 32'd16);
    chk("l1_quotient",  32'(busa.res_quotient),  32'h0E);
    chk("l1_remainder", 32'(busa.res_remainder), 32'h02);
    chk("l15_quotient",  32'(busb.res_quotient),  32'h0E);
    chk("l15_remainder", 32'(busb.res_remainder), 32'h02);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
